// File: rtl/fetch_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctl_if
//  Description : Instruction-memory request/response bus between the fetch
//                controller (master) and instruction memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctl_if;
   logic        req;     // read request, held until accepted
   logic [31:0] addr;    // request address
   logic        ready;   // memory accepts the request this cycle
   logic        rvalid;  // read data valid
   logic [31:0] rdata;   // instruction word

   modport master (
      output req,
      output addr,
      input  ready,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output ready,
      output rvalid,
      output rdata
   );
endinterface
`default_nettype wire

// File: rtl/fetch_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctl
//  Description : Multicycle sequencing controller and instruction fetch unit.
//                Owns the PC, runs the instruction-memory handshake, latches
//                the instruction for the decoder, waits on data memory and
//                resolves the next PC from branch controls / ALU result.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          COUNT_W  = 32
) (
   input  wire logic               clk,
   input  wire logic               rst,

   // instruction-memory bus
   fetch_ctl_if.master             imem,

   // phase and fetched instruction
   output logic [2:0]              state,
   output logic [31:0]             pc,
   output logic [31:0]             instr_raw,

   // decoder / ALU controls
   input  wire logic               branch_uc,
   input  wire logic               branch_c,
   input  wire logic               branch_relative,
   input  wire logic [31:0]        imm,
   input  wire logic [31:0]        alu_result,
   input  wire logic               mem_read,
   input  wire logic               mem_write,
   input  wire logic               dmem_done,
   input  wire logic               reg_write,

   // write-back and status
   output logic                    wb_en,
   output logic [31:0]             link_pc,
   output logic                    fault,
   output logic [COUNT_W-1:0]      retired
);

   // Externally visible phase codes. FETCH hides two substates (REQ/RESP)
   // distinguished by r_wait.
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WRITE  = 3'd4;
   localparam logic [2:0] S_FAULT  = 3'd5;

   localparam logic [COUNT_W-1:0] c_count_one = COUNT_W'(1);

   logic [2:0]          r_state;
   logic                r_wait;     // 0: FETCH/REQ, 1: FETCH/RESP
   logic                r_req;      // registered imem request
   logic [31:0]         r_pc;
   logic [31:0]         r_npc;      // next PC resolved in EXEC
   logic [31:0]         r_instr;
   logic [COUNT_W-1:0]  r_retired;

   logic [31:0]         w_pc_rel;
   logic [31:0]         w_pc_seq;
   logic [31:0]         w_target;
   logic                w_misaligned;
   logic                w_mem_op;

   // Next-PC resolution; unconditional jumps outrank conditional branches.
   always_comb begin
      w_pc_rel = r_pc + imm;
      w_pc_seq = r_pc + 32'd4;
      w_target = w_pc_seq;
      if (branch_uc) begin
         if (branch_relative) begin
            w_target = w_pc_rel;
         end else begin
            w_target = {alu_result[31:1], 1'b0};
         end
      end else if (branch_c && alu_result[0]) begin
         w_target = w_pc_rel;
      end
      w_misaligned = (w_target[1:0] != 2'b00);
      w_mem_op     = mem_read | mem_write;
   end

   // Phase sequencing, including the hidden FETCH request/response substates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_wait  <= 1'b0;
         r_req   <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (!r_wait) begin
                  // After reset the request is raised one cycle late;
                  // after WRITE it is already up on FETCH entry.
                  if (!r_req) begin
                     r_req <= 1'b1;
                  end else if (imem.ready) begin
                     r_req  <= 1'b0;
                     r_wait <= 1'b1;
                  end
               end else if (imem.rvalid) begin
                  r_wait  <= 1'b0;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               if (w_misaligned) begin
                  r_state <= S_FAULT;
               end else if (w_mem_op) begin
                  r_state <= S_MEM;
               end else begin
                  r_state <= S_WRITE;
               end
            end
            S_MEM: begin
               if (dmem_done) begin
                  r_state <= S_WRITE;
               end
            end
            S_WRITE: begin
               r_state <= S_FETCH;
               r_wait  <= 1'b0;
               r_req   <= 1'b1;
            end
            S_FAULT: begin
               r_state <= S_FAULT;
               r_req   <= 1'b0;
            end
            default: begin
               // Unreachable codes park in FAULT rather than run wild.
               r_state <= S_FAULT;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   // Instruction latch: only the RESP data beat may update it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr <= 32'd0;
      end else if (r_state == S_FETCH && r_wait && imem.rvalid) begin
         r_instr <= imem.rdata;
      end
   end

   // Next-PC register captures the resolved target when leaving EXEC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_npc <= 32'd0;
      end else if (r_state == S_EXEC) begin
         r_npc <= w_target;
      end
   end

   // PC and retirement counter advance together on WRITE exit only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc      <= RESET_PC;
         r_retired <= '0;
      end else if (r_state == S_WRITE) begin
         r_pc      <= r_npc;
         r_retired <= r_retired + c_count_one;
      end
   end

   // Output mapping.
   always_comb begin
      state      = r_state;
      pc         = r_pc;
      instr_raw  = r_instr;
      imem.req   = r_req;
      imem.addr  = r_pc;
      wb_en      = (r_state == S_WRITE) && reg_write;
      link_pc    = r_pc + 32'd4;
      fault      = (r_state == S_FAULT);
      retired    = r_retired;
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctl
//  Description : Self-checking bench for fetch_ctl. Directed instruction
//                stream; retirements are checked by a scoreboard monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctl;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  state;
   logic [31:0] pc, instr_raw, link_pc;
   logic        branch_uc, branch_c, branch_relative;
   logic [31:0] imm, alu_result;
   logic        mem_read, mem_write, dmem_done, reg_write;
   logic        wb_en, fault;
   logic [3:0]  retired;

   fetch_ctl_if imem_bus ();

   fetch_ctl #(.RESET_PC(32'h0000_0000), .COUNT_W(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem            (imem_bus),
      .state           (state),
      .pc              (pc),
      .instr_raw       (instr_raw),
      .branch_uc       (branch_uc),
      .branch_c        (branch_c),
      .branch_relative (branch_relative),
      .imm             (imm),
      .alu_result      (alu_result),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .dmem_done       (dmem_done),
      .reg_write       (reg_write),
      .wb_en           (wb_en),
      .link_pc         (link_pc),
      .fault           (fault),
      .retired         (retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] link;
      logic [31:0] word;
      logic        wb;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_pc  = 32'd0;
   logic [31:0] exp_raw = 32'd0;
   logic [3:0]  exp_ret = 4'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every WRITE cycle retires the oldest expected entry.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (state == 3'd4) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected_write: got WRITE at pc %h expected no retirement", pc);
            end else begin
               mon_e = sb.pop_front();
               check("sb_pc", pc, mon_e.pc);
               check("sb_link", link_pc, mon_e.link);
               check("sb_wb", 32'(wb_en), 32'(mon_e.wb));
               check("sb_instr", instr_raw, mon_e.word);
            end
         end else begin
            check("wb_idle", 32'(wb_en), 32'd0);
         end
      end
   end

   task automatic clear_ctl();
      branch_uc = 0; branch_c = 0; branch_relative = 0;
      imm = 0; alu_result = 0;
      mem_read = 0; mem_write = 0; dmem_done = 0; reg_write = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_bus.ready = 0; imem_bus.rvalid = 0; imem_bus.rdata = 0;
      clear_ctl();
      @(posedge clk);
      #1;
      exp_pc = 32'd0; exp_raw = 32'd0; exp_ret = 4'd0;
      check("rst_state", 32'(state), 32'd0);
      check("rst_pc", pc, 32'd0);
      check("rst_req", 32'(imem_bus.req), 32'd0);
      check("rst_instr", instr_raw, 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_retired", 32'(retired), 32'd0);
      rst = 1'b0;
      step();
      check("post_rst_req", 32'(imem_bus.req), 32'd1);
   endtask

   // One complete instruction: fetch with optional stall, then the controls.
   // Garbage rvalid beats are driven during stall and acceptance cycles.
   task automatic run_instr(input logic [31:0] word,
                            input logic buc, input logic bc, input logic brel,
                            input logic [31:0] im, input logic [31:0] alu,
                            input logic mr, input logic mw, input logic rw,
                            input int dlat, input int stall,
                            input logic [31:0] exp_npc, input logic exp_fault);
      int n = 0;
      int cyc = 0;
      exp_t e;
      while (imem_bus.req !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      check("req_up", 32'(imem_bus.req), 32'd1);
      check("req_addr", imem_bus.addr, exp_pc);
      check("pc_cur", pc, exp_pc);
      for (int i = 0; i < stall; i++) begin
         imem_bus.ready = 0; imem_bus.rvalid = 1; imem_bus.rdata = ~word;
         step(); cyc++;
         check("stall_req", 32'(imem_bus.req), 32'd1);
         check("stall_addr", imem_bus.addr, exp_pc);
         check("stall_state", 32'(state), 32'd0);
         check("stall_instr", instr_raw, exp_raw);
      end
      imem_bus.ready = 1; imem_bus.rvalid = 1; imem_bus.rdata = ~word;
      step(); cyc++;
      imem_bus.ready = 0;
      check("resp_req", 32'(imem_bus.req), 32'd0);
      check("resp_state", 32'(state), 32'd0);
      check("resp_instr", instr_raw, exp_raw);
      imem_bus.rvalid = 1; imem_bus.rdata = word;
      step(); cyc++;
      imem_bus.rvalid = 0;
      exp_raw = word;
      check("dec_state", 32'(state), 32'd1);
      check("dec_instr", instr_raw, word);
      branch_uc = buc; branch_c = bc; branch_relative = brel;
      imm = im; alu_result = alu; mem_read = mr; mem_write = mw; reg_write = rw;
      step(); cyc++;
      check("exec_state", 32'(state), 32'd2);
      if (!exp_fault) begin
         e.pc = exp_pc; e.link = exp_pc + 32'd4; e.word = word; e.wb = rw;
         sb.push_back(e);
      end
      step(); cyc++;
      if (exp_fault) begin
         check("fault_state", 32'(state), 32'd5);
         check("fault_flag", 32'(fault), 32'd1);
         for (int i = 0; i < 4; i++) begin
            imem_bus.ready = 1;
            step();
            check("fault_hold", 32'(state), 32'd5);
            check("fault_sticky", 32'(fault), 32'd1);
            check("fault_req", 32'(imem_bus.req), 32'd0);
            check("fault_pc", pc, exp_pc);
            check("fault_retired", 32'(retired), 32'(exp_ret));
            check("fault_instr", instr_raw, word);
         end
         imem_bus.ready = 0;
         clear_ctl();
         return;
      end
      if (mr || mw) begin
         for (int k = 1; k <= dlat; k++) begin
            check("mem_state", 32'(state), 32'd3);
            dmem_done = (k == dlat);
            step(); cyc++;
         end
         dmem_done = 0;
      end
      check("wr_state", 32'(state), 32'd4);
      check("wr_instr", instr_raw, word);
      step(); cyc++;
      exp_ret = exp_ret + 4'd1;
      check("next_state", 32'(state), 32'd0);
      check("next_pc", pc, exp_npc);
      check("retired", 32'(retired), 32'(exp_ret));
      check("cycles", 32'(cyc), 32'(5 + stall + ((mr || mw) ? dlat : 0)));
      exp_pc = exp_npc;
      clear_ctl();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      imem_bus.ready = 0; imem_bus.rvalid = 0; imem_bus.rdata = 0;
      clear_ctl();
      do_reset();

      // 1: addi, minimum latency, pc 0 -> 4
      run_instr(32'h0050_0093, 0,0,0, 32'd0, 32'd0, 0,0,1, 0, 0, 32'h4, 0);

      // 2: jal to 0x40, jal +0x100 -> 0x140, jalr to 0x202 faults
      run_instr(32'h03C0_00EF, 1,0,1, 32'h3C,  32'd0,   0,0,1, 0, 0, 32'h40,  0);
      run_instr(32'h1000_00EF, 1,0,1, 32'h100, 32'd0,   0,0,1, 0, 0, 32'h140, 0);
      run_instr(32'h0000_80E7, 1,0,0, 32'd0,   32'h203, 0,0,1, 0, 0, 32'h202, 1);
      do_reset();

      // 3: bge taken / not taken, jump priority over branch
      run_instr(32'h0100_006F, 1,0,1, 32'h10,        32'd0,   0,0,0, 0, 0, 32'h10,  0);
      run_instr(32'hFE20_DCE3, 0,1,0, 32'hFFFF_FFF8, 32'd1,   0,0,0, 0, 0, 32'h08,  0);
      run_instr(32'h0080_006F, 1,0,1, 32'h8,         32'd0,   0,0,0, 0, 0, 32'h10,  0);
      run_instr(32'hFE20_DCE3, 0,1,0, 32'hFFFF_FFF8, 32'd0,   0,0,0, 0, 0, 32'h14,  0);
      run_instr(32'h0000_80E7, 1,1,0, 32'h40,        32'h101, 0,0,1, 0, 0, 32'h100, 0);

      // 4: lw with 3-cycle MEM, sw with immediate completion
      run_instr(32'h0000_A103, 0,0,0, 32'd0, 32'd0, 1,0,1, 3, 0, 32'h104, 0);
      run_instr(32'h0020_A023, 0,0,0, 32'd0, 32'd0, 0,1,0, 1, 0, 32'h108, 0);

      // 5: fetch stall, then reset while waiting for the response
      run_instr(32'h0010_0093, 0,0,0, 32'd0, 32'd0, 0,0,1, 0, 4, 32'h10C, 0);
      check("pre_resp_req", 32'(imem_bus.req), 32'd1);
      imem_bus.ready = 1;
      step();
      imem_bus.ready = 0;
      check("in_resp_req", 32'(imem_bus.req), 32'd0);
      rst = 1'b1;
      #1;
      check("async_rst_pc", pc, 32'd0);
      do_reset();
      run_instr(32'h0010_0093, 0,0,0, 32'd0, 32'd0, 0,0,1, 0, 2, 32'h4, 0);

      // 6: pc wrap at top of memory, retirement counter wrap
      run_instr(32'hFF9F_F0EF, 1,0,1, 32'hFFFF_FFF8, 32'd0, 0,0,1, 0, 0, 32'hFFFF_FFFC, 0);
      run_instr(32'h0000_0013, 0,0,0, 32'd0, 32'd0, 0,0,1, 0, 0, 32'h0, 0);
      for (int i = 3; i < 16; i++) begin
         run_instr(32'h0000_0013, 0,0,0, 32'd0, 32'd0, 0,0,0, 0, 0, exp_pc + 32'd4, 0);
      end
      check("retired_wrap", 32'(retired), 32'd0);

      repeat (2) step();
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
